// File: rtl/nios_system_cpu_dct_packer.sv
// nios_system_cpu_dct_packer
//
// Packs 2-bit on-chip-debug trace codes into 30-bit frames of up to 15 slots
// (slot i lives in bits [2i+1:2i]) and hands finished frames to the trace RAM
// writer. It also runs the end-of-test drain, so simulation only stops once
// all captured trace has been written out.
//
// Optional feature macro: DCT_BACKPRESSURE_EN
//   defined   : code_ready drops while the accumulator is full and the holding
//               register is busy; no code is ever dropped.
//   undefined : code_ready is always 1 out of reset; a code that arrives while
//               the accumulator is full and the holding register is busy is
//               dropped and sets the sticky overflow flag.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   trace_enable        codes are accepted only while high
//   code_valid/code     trace code input; code_ready is the registered ready
//   flush               one-cycle pulse: emit the partial frame
//   out_valid/out_ready frame handshake towards the trace RAM
//   dct_buffer          frame data (unused upper slots are zero)
//   dct_count           number of valid slots, 1..15
//   overflow/ovf_clear  sticky drop flag and its clear
//   test_ending         level request for the end-of-test drain
//   test_has_ended      sticky, set once the drain is complete
//   dbg_state           current FSM state (RUN=0, DRAIN=1, DONE=2)
//
// Handshake: a transfer happens on every rising clk edge where valid and
// ready are both high; valid, once raised, holds its data stable until that
// edge, and ready never depends combinationally on valid.

module nios_system_cpu_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trace_enable,
  input  logic        code_valid,
  input  logic [1:0]  code,
  output logic        code_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  input  logic        ovf_clear,
  input  logic        test_ending,
  output logic        test_has_ended,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [29:0] acc_data_q, acc_data_d;
  logic [3:0]  acc_cnt_q, acc_cnt_d;
  logic [29:0] hold_data_q, hold_data_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic        flush_pend_q, flush_pend_d;
  logic        overflow_q, overflow_d;
  logic        code_ready_q, code_ready_d;
  logic        ended_q;

  logic        take, hold_free, acc_full, flush_eff, xfer, drop;
  logic [29:0] m_data;
  logic [3:0]  m_cnt;

  always_comb begin
    take      = code_valid && code_ready_q && trace_enable && (state_q == ST_RUN);
    hold_free = !out_valid_q || out_ready;
    acc_full  = (acc_cnt_q == 4'd15);
    // DRAIN behaves like a flush that stays asserted.
    flush_eff = flush_pend_q || (state_q == ST_DRAIN);
    m_data    = acc_data_q;
    m_cnt     = acc_cnt_q;
    xfer      = 1'b0;
    drop      = 1'b0;

    if (acc_full) begin
      // A full accumulator moves out as soon as the holding slot frees up;
      // a code arriving while it cannot move has nowhere to go.
      xfer = hold_free;
      drop = take && !hold_free;
    end else begin
      // A code accepted on this edge joins the frame that may leave on it.
      if (take) begin
        m_data[{acc_cnt_q, 1'b0} +: 2] = code;
        m_cnt = acc_cnt_q + 4'd1;
      end
      xfer = hold_free && ((m_cnt == 4'd15) || (flush_eff && (m_cnt != 4'd0)));
    end

    acc_data_d  = m_data;
    acc_cnt_d   = m_cnt;
    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    if (xfer) begin
      hold_data_d = m_data;
      hold_cnt_d  = m_cnt;
      out_valid_d = 1'b1;
      acc_data_d  = '0;
      acc_cnt_d   = 4'd0;
      // Full accumulator leaving while a new code arrives: code opens the next frame.
      if (acc_full && take) begin
        acc_data_d = {28'd0, code};
        acc_cnt_d  = 4'd1;
      end
    end

    // A flush that would leave an empty accumulator is discarded.
    flush_pend_d = (flush_pend_q && !xfer) || (flush && (acc_cnt_d != 4'd0));
    // Set wins over clear.
    overflow_d   = drop || (overflow_q && !ovf_clear);

`ifdef DCT_BACKPRESSURE_EN
    // Accumulator still full after this edge means the holding slot is busy.
    code_ready_d = (acc_cnt_d != 4'd15);
`else
    code_ready_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      acc_data_q   <= '0;
      acc_cnt_q    <= '0;
      hold_data_q  <= '0;
      hold_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      code_ready_q <= 1'b0;
      ended_q      <= 1'b0;
    end else begin
      acc_data_q   <= acc_data_d;
      acc_cnt_q    <= acc_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_cnt_q   <= hold_cnt_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
      code_ready_q <= code_ready_d;
      case (state_q)
        ST_RUN: begin
          if (test_ending) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Done once the last handshake has emptied everything.
          if ((acc_cnt_q == 4'd0) && !out_valid_q) begin
            state_q <= ST_DONE;
            ended_q <= 1'b1;
          end
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  assign code_ready     = code_ready_q;
  assign out_valid      = out_valid_q;
  assign dct_buffer     = hold_data_q;
  assign dct_count      = hold_cnt_q;
  assign overflow       = overflow_q;
  assign test_has_ended = ended_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_nios_system_cpu_dct_packer.sv
module tb_nios_system_cpu_dct_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, trace_enable, code_valid, flush, out_ready, ovf_clear, test_ending;
  logic [1:0]  code;
  logic        code_ready, out_valid, overflow, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  nios_system_cpu_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable),
    .code_valid(code_valid), .code(code), .code_ready(code_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
    .ovf_clear(ovf_clear), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  int          acc_m[$];
  bit          hv_m, pend_m, ovf_m, rdy_m, end_m;
  logic [29:0] hd_m;
  logic [3:0]  hc_m;
  int          st_m;   // 0 run, 1 drain, 2 done

  function automatic logic [29:0] pack_q(input int q[$], input int lo, input int n);
    logic [29:0] r = '0;
    for (int i = 0; i < n; i++) r[2*i +: 2] = 2'(q[lo+i]);
    return r;
  endfunction

  task automatic model_reset();
    acc_m.delete();
    hv_m = 0; pend_m = 0; ovf_m = 0; rdy_m = 0; end_m = 0; st_m = 0;
    hd_m = '0; hc_m = '0;
  endtask

  // Advance the model by one clock edge using the inputs now applied, then
  // move the DUT by the same edge and settle just after it.
  task automatic tick();
    int  frame[$];
    int  st0   = st_m;
    bit  hv0   = hv_m;
    bit  empty0 = (acc_m.size() == 0);
    bit  take  = code_valid && rdy_m && trace_enable && (st0 == 0);
    bit  free  = !hv_m || out_ready;
    bit  send  = 0;
    bit  drop  = 0;
    if (acc_m.size() == 15) begin
      if (free) begin
        frame = acc_m; send = 1; acc_m.delete();
        if (take) acc_m.push_back(int'(code));
      end else if (take) drop = 1;
    end else begin
      if (take) acc_m.push_back(int'(code));
      if (free && (acc_m.size() == 15 || ((pend_m || st0 == 1) && acc_m.size() > 0))) begin
        frame = acc_m; send = 1; acc_m.delete();
      end
    end
    if (send) begin
      hd_m = pack_q(frame, 0, frame.size());
      hc_m = 4'(frame.size());
      hv_m = 1; pend_m = 0;
    end else if (hv_m && out_ready) hv_m = 0;
    if (flush && acc_m.size() > 0) pend_m = 1;
    if (drop) ovf_m = 1; else if (ovf_clear) ovf_m = 0;
    if (st0 == 0 && test_ending) st_m = 1;
    else if (st0 == 1 && empty0 && !hv0) begin st_m = 2; end_m = 1; end
`ifdef DCT_BACKPRESSURE_EN
    rdy_m = (acc_m.size() != 15);
`else
    rdy_m = 1;
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    trace_enable = 1; code_valid = 0; code = 0; flush = 0;
    out_ready = 0; ovf_clear = 0; test_ending = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    tick();
  endtask

  task automatic send_code(input logic [1:0] c);
    code_valid = 1; code = c;
    tick();
    code_valid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, overflow, test_has_ended, code_ready, dct_count, dct_buffer} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got ov=%b ovf=%b end=%b rdy=%b cnt=%0d buf=%h, want all 0",
               out_valid, overflow, test_has_ended, code_ready, dct_count, dct_buffer);
    end
    reset_n = 1;
    tick();
    n_vec++;
    if (code_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", code_ready);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 15; i++) begin
      send_code(2'(i % 4));
      code_valid = 1;
      if (i == 13) begin
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_early: out_valid %b want 0", out_valid); end
      end
    end
    n_vec++;
    if ({out_valid, dct_count, dct_buffer} !== {1'b1, 4'd15, 30'h24E4E4E4}) begin
      n_err++;
      $display("FAIL full_frame: got ov=%b cnt=%0d buf=%h want 1 15 24e4e4e4", out_valid, dct_count, dct_buffer);
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    // Continues right after test_full_frame with out_ready still high.
    for (int i = 15; i < 30; i++) begin
      exp_q.push_back(i % 4);
      send_code(2'(i % 4));
      code_valid = 1;
      n_vec++;
      if (code_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1 at %0d", code_ready, i); end
    end
    code_valid = 0;
    n_vec++;
    if ({out_valid, dct_count, dct_buffer} !== {1'b1, 4'd15, pack_q(exp_q, 0, 15)}) begin
      n_err++;
      $display("FAIL b2b_frame: got ov=%b cnt=%0d buf=%h want 1 15 %h",
               out_valid, dct_count, dct_buffer, pack_q(exp_q, 0, 15));
    end
  endtask

  task automatic test_partial();
    do_reset();
    out_ready = 1;
    send_code(2'd3); send_code(2'd2); send_code(2'd1);
    flush = 1; tick(); flush = 0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL partial_early: out_valid %b want 0", out_valid); end
    tick();
    n_vec++;
    if ({out_valid, dct_count, dct_buffer} !== {1'b1, 4'd3, 30'b011011}) begin
      n_err++;
      $display("FAIL partial_frame: got ov=%b cnt=%0d buf=%h want 1 3 1b", out_valid, dct_count, dct_buffer);
    end
    tick();
    flush = 1; tick(); flush = 0;
    repeat (3) tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_flush: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int sent[$];
    logic [1:0] c31;
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 30; i++) begin
      sent.push_back(int'($urandom_range(0, 3)));
      send_code(2'(sent[i]));
    end
    c31 = 2'($urandom_range(0, 3));
    n_vec++;
    if ({out_valid, dct_count, dct_buffer} !== {1'b1, 4'd15, pack_q(sent, 0, 15)}) begin
      n_err++;
      $display("FAIL bp_frame1: got ov=%b cnt=%0d buf=%h want 1 15 %h",
               out_valid, dct_count, dct_buffer, pack_q(sent, 0, 15));
    end
`ifdef DCT_BACKPRESSURE_EN
    n_vec++;
    if (code_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall: code_ready %b want 0", code_ready); end
    code_valid = 1; code = c31;
    repeat (2) tick();
    out_ready = 1; tick(); out_ready = 0;
    n_vec++;
    if ({code_ready, out_valid, dct_count, dct_buffer} !== {1'b1, 1'b1, 4'd15, pack_q(sent, 15, 15)}) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b ov=%b cnt=%0d buf=%h want 1 1 15 %h",
               code_ready, out_valid, dct_count, dct_buffer, pack_q(sent, 15, 15));
    end
    tick(); code_valid = 0;
    flush = 1; tick(); flush = 0;
    out_ready = 1; tick(); out_ready = 0;
    n_vec++;
    if ({overflow, out_valid, dct_count, dct_buffer} !== {1'b0, 1'b1, 4'd1, {28'd0, c31}}) begin
      n_err++;
      $display("FAIL bp_code31: got ovf=%b ov=%b cnt=%0d buf=%h want 0 1 1 %h",
               overflow, out_valid, dct_count, dct_buffer, {28'd0, c31});
    end
`else
    send_code(c31);
    n_vec++;
    if ({overflow, out_valid, dct_buffer} !== {1'b1, 1'b1, pack_q(sent, 0, 15)}) begin
      n_err++;
      $display("FAIL bp_drop: got ovf=%b ov=%b buf=%h want 1 1 %h",
               overflow, out_valid, dct_buffer, pack_q(sent, 0, 15));
    end
    out_ready = 1; tick();
    n_vec++;
    if ({out_valid, dct_count, dct_buffer} !== {1'b1, 4'd15, pack_q(sent, 15, 15)}) begin
      n_err++;
      $display("FAIL bp_frame2: got ov=%b cnt=%0d buf=%h want 1 15 %h",
               out_valid, dct_count, dct_buffer, pack_q(sent, 15, 15));
    end
    ovf_clear = 1; flush = 1; tick(); ovf_clear = 0; flush = 0;
    tick();
    n_vec++;
    if ({overflow, out_valid} !== 2'b00) begin
      n_err++; $display("FAIL bp_clear: got ovf=%b ov=%b want 0 0 (dropped code not stored)", overflow, out_valid);
    end
`endif
  endtask

  task automatic test_flush_with_code();
    int c[$];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      c.push_back(int'($urandom_range(0, 3)));
      send_code(2'(c[i]));
    end
    c.push_back(2);
    flush = 1; code_valid = 1; code = 2'd2;
    tick();
    flush = 0; code_valid = 0;
    tick();
    n_vec++;
    if ({out_valid, dct_count, dct_buffer[9:8], dct_buffer} !== {1'b1, 4'd5, 2'd2, pack_q(c, 0, 5)}) begin
      n_err++;
      $display("FAIL flush_code: got ov=%b cnt=%0d buf=%h want 1 5 %h", out_valid, dct_count, dct_buffer, pack_q(c, 0, 5));
    end
  endtask

  task automatic test_end_of_test();
    int c[$];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      c.push_back(int'($urandom_range(0, 3)));
      send_code(2'(c[i]));
    end
    test_ending = 1;
    repeat (3) tick();
    n_vec++;
    if ({out_valid, dct_count, dct_buffer, test_has_ended} !== {1'b1, 4'd5, pack_q(c, 0, 5), 1'b0}) begin
      n_err++;
      $display("FAIL end_frame: got ov=%b cnt=%0d buf=%h end=%b want 1 5 %h 0",
               out_valid, dct_count, dct_buffer, test_has_ended, pack_q(c, 0, 5));
    end
    out_ready = 1; tick();
    n_vec++;
    if ({out_valid, test_has_ended} !== 2'b00) begin
      n_err++; $display("FAIL end_handshake: got ov=%b end=%b want 0 0", out_valid, test_has_ended);
    end
    tick();
    n_vec++;
    if (test_has_ended !== 1'b1) begin n_err++; $display("FAIL end_done: got %b want 1", test_has_ended); end
    test_ending = 0;
    for (int i = 0; i < 20; i++) begin
      code_valid = 1; code = 2'($urandom_range(0, 3)); flush = (i % 5 == 0);
      tick();
    end
    code_valid = 0; flush = 0;
    tick();
    n_vec++;
    if ({out_valid, test_has_ended, dbg_state} !== {1'b0, 1'b1, 2'd2}) begin
      n_err++; $display("FAIL end_ignored: got ov=%b end=%b st=%0d want 0 1 2", out_valid, test_has_ended, dbg_state);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] c;
    do_reset();
    for (int i = 0; i < 22; i++) send_code(2'($urandom_range(0, 3)));
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_setup: out_valid %b want 1", out_valid); end
    #2;
    reset_n = 0;
    model_reset();
    #1;
    n_vec++;
    if ({out_valid, overflow, test_has_ended, code_ready, dct_count, dct_buffer} !== 38'd0) begin
      n_err++;
      $display("FAIL rmid_outputs: got ov=%b ovf=%b end=%b rdy=%b cnt=%0d buf=%h want all 0",
               out_valid, overflow, test_has_ended, code_ready, dct_count, dct_buffer);
    end
    @(posedge clk); #1;
    reset_n = 1;
    tick();
    c = 2'($urandom_range(1, 3));
    out_ready = 1;
    send_code(c);
    flush = 1; tick(); flush = 0;
    tick();
    n_vec++;
    if ({out_valid, dct_count, dct_buffer} !== {1'b1, 4'd1, {28'd0, c}}) begin
      n_err++;
      $display("FAIL rmid_restart: got ov=%b cnt=%0d buf=%h want 1 1 %h", out_valid, dct_count, dct_buffer, {28'd0, c});
    end
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ready_pct = int'($urandom_range(0, 100));
      trace_enable = ($urandom_range(0, 7) != 0);
      code_valid   = ($urandom_range(0, 3) != 0);
      code         = 2'($urandom_range(0, 3));
      flush        = ($urandom_range(0, 15) == 0);
      out_ready    = (int'($urandom_range(0, 99)) < ready_pct);
      ovf_clear    = ($urandom_range(0, 31) == 0);
      tick();
      n_vec++;
      if ({out_valid, overflow, code_ready, test_has_ended} !== {hv_m, ovf_m, rdy_m, end_m}) begin
        n_err++;
        $display("FAIL rand_ctl@%0d: got ov=%b ovf=%b rdy=%b end=%b want %b %b %b %b",
                 i, out_valid, overflow, code_ready, test_has_ended, hv_m, ovf_m, rdy_m, end_m);
      end
      if (hv_m) begin
        n_vec++;
        if ({dct_count, dct_buffer} !== {hc_m, hd_m}) begin
          n_err++;
          $display("FAIL rand_frame@%0d: got cnt=%0d buf=%h want %0d %h", i, dct_count, dct_buffer, hc_m, hd_m);
        end
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_partial();
    test_backpressure();
    test_flush_with_code();
    test_random();
    test_end_of_test();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
